// File: rtl/counter_60_pkg.sv
`default_nettype none
// ============================================================================
// counter_60_pkg : shared moduli and widths for timekeeping counter stages
// Revision       : 1.0
// ============================================================================
package counter_60_pkg;

    // Binary seconds/minutes stage
    localparam int TK_MODULO = 60;
    localparam int TK_WIDTH  = 6;

    // Digit moduli for BCD seconds/minutes variants (units, tens)
    localparam int BCD_MOD10 = 10;
    localparam int BCD_MOD6  = 6;

endpackage : counter_60_pkg
`default_nettype wire

// File: rtl/counter_60_mod_n_counter.sv
`default_nettype none
// ============================================================================
// mod_n_counter : generic modulo-N up-counter with terminal-count decode
// Revision      : 1.0
// ============================================================================
module mod_n_counter
    import counter_60_pkg::*;
#(
    parameter int N = TK_MODULO,
    parameter int W = TK_WIDTH
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc
);

    localparam logic [W-1:0] last_count = W'(N - 1);

    // Using >= folds any out-of-range value (e.g. after an upset) into the wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            if (q >= last_count) begin
                q <= '0;
            end else begin
                q <= q + W'(1);
            end
        end
    end

    assign tc = (q == last_count);

endmodule : mod_n_counter
`default_nettype wire

// File: rtl/counter_60.sv
`default_nettype none
// ============================================================================
// counter_60 : free-running modulo-60 counter, seconds/minutes stage
// Revision   : 1.0
// ============================================================================
module counter_60
    import counter_60_pkg::*;
#(
    parameter int MODULO = TK_MODULO,
    parameter int WIDTH  = TK_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] nums,
    output logic             cout
);

    mod_n_counter #(
        .N (MODULO),
        .W (WIDTH)
    ) u_counter (
        .clk  (clk),
        .rstn (rstn),
        .en   (1'b1),
        .q    (nums),
        .tc   (cout)
    );

endmodule : counter_60
`default_nettype wire

// File: tb/tb_counter_60.sv
`default_nettype none
// ============================================================================
// tb_counter_60 : randomized self-checking bench for counter_60
// Revision      : 1.0
// ============================================================================
module tb_counter_60;

    logic       clk;
    logic       rstn;
    logic [5:0] nums;
    logic       cout;

    int tests;
    int fails;
    int k;          // rising edges seen since the last reset release

    counter_60 #(
        .MODULO (60),
        .WIDTH  (6)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .nums (nums),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count is simply edges-since-release modulo 60
    function automatic logic [5:0] ref_nums(input int edges);
        return 6'(edges % 60);
    endfunction

    function automatic logic ref_cout(input int edges);
        return (edges % 60) == 59;
    endfunction

    // Stimulus only: clean reset pulse, released 1 ns before a rising edge
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #4;
        rstn = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        tests++;
        if (nums !== 6'd0 || cout !== 1'b0) begin
            fails++;
            $display("FAIL reset_early: nums=%0d cout=%0b, required nums=0 cout=0", nums, cout);
        end
        #6;  // a rising edge has passed while held in reset
        tests++;
        if (nums !== 6'd0 || cout !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: nums=%0d cout=%0b, required nums=0 cout=0", nums, cout);
        end
        #4;
        rstn = 1'b1;
        k = 0;
        @(posedge clk);
        k++;
        #1;
        tests++;
        if (nums !== 6'd1 || cout !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: nums=%0d cout=%0b, required nums=1 cout=0", nums, cout);
        end
    endtask

    task automatic test_full_sequence();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            k++;
            #1;
            if (cout === 1'b1) pulses++;
            tests++;
            if (nums !== ref_nums(k) || cout !== ref_cout(k)) begin
                fails++;
                $display("FAIL full_seq edge %0d: nums=%0d cout=%0b, required nums=%0d cout=%0b",
                         k, nums, cout, ref_nums(k), ref_cout(k));
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL full_seq_pulses: got %0d cout pulses, required 1", pulses);
        end
    endtask

    task automatic test_wrap_second_lap();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            k++;
            #1;
            if (cout === 1'b1) pulses++;
            if (k == 59 || k == 60 || k == 70) begin
                tests++;
                if (nums !== 6'(k % 60) || cout !== (k == 59)) begin
                    fails++;
                    $display("FAIL wrap edge %0d: nums=%0d cout=%0b, required nums=%0d cout=%0b",
                             k, nums, cout, k % 60, (k == 59));
                end
            end
        end
        // cout must go low exactly one clock after it rose at edge 59
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL wrap_pulses: got %0d cout-high samples in 70 edges, required 1", pulses);
        end
    endtask

    task automatic test_async_reset_mid();
        do_reset();
        repeat (70) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        tests++;
        if (nums !== ref_nums(k)) begin
            fails++;
            $display("FAIL async_pre: nums=%0d, required %0d", nums, ref_nums(k));
        end
        rstn = 1'b0;
        #2;
        tests++;
        if (nums !== 6'd0 || cout !== 1'b0) begin
            fails++;
            $display("FAIL async_clear: nums=%0d cout=%0b, required nums=0 cout=0", nums, cout);
        end
        #2;
        rstn = 1'b1;
        k = 0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            k++;
            #1;
            tests++;
            if (nums !== 6'(i)) begin
                fails++;
                $display("FAIL async_resume %0d: nums=%0d, required %0d", i, nums, i);
            end
        end
    endtask

    task automatic test_reset_at_terminal();
        do_reset();
        repeat (59) begin
            @(posedge clk);
            k++;
        end
        #1;
        tests++;
        if (nums !== 6'd59 || cout !== 1'b1) begin
            fails++;
            $display("FAIL term_pre: nums=%0d cout=%0b, required nums=59 cout=1", nums, cout);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests++;
        if (nums !== 6'd0 || cout !== 1'b0) begin
            fails++;
            $display("FAIL term_clear: nums=%0d cout=%0b, required nums=0 cout=0", nums, cout);
        end
        #1;
        rstn = 1'b1;
        k = 0;
        for (int i = 1; i <= 59; i++) begin
            @(posedge clk);
            k++;
            #1;
            tests++;
            if (cout !== (i == 59)) begin
                fails++;
                $display("FAIL term_relap edge %0d: cout=%0b, required %0b", i, cout, (i == 59));
            end
        end
    endtask

    task automatic test_long_run();
        do_reset();
        repeat (20) begin
            @(posedge clk);
            k++;
        end
        #1;
        tests++;
        if (nums !== 6'd20 || cout !== 1'b0) begin
            fails++;
            $display("FAIL long_run: nums=%0d cout=%0b, required nums=20 cout=0", nums, cout);
        end
    endtask

    // Random reset pulses (possibly spanning clock edges) against the reference
    task automatic test_random();
        int n_low;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            k++;
            #1;
            tests++;
            if (nums !== ref_nums(k) || cout !== ref_cout(k)) begin
                fails++;
                $display("FAIL random iter %0d: nums=%0d cout=%0b, required nums=%0d cout=%0b",
                         i, nums, cout, ref_nums(k), ref_cout(k));
            end
            if ($urandom_range(0, 24) == 0) begin
                n_low = int'($urandom_range(0, 2));
                #($urandom_range(1, 3));
                rstn = 1'b0;
                #1;
                tests++;
                if (nums !== 6'd0 || cout !== 1'b0) begin
                    fails++;
                    $display("FAIL random_reset iter %0d: nums=%0d cout=%0b, required nums=0 cout=0",
                             i, nums, cout);
                end
                repeat (n_low) #10;
                #1;
                tests++;
                if (nums !== 6'd0 || cout !== 1'b0) begin
                    fails++;
                    $display("FAIL random_hold iter %0d: nums=%0d cout=%0b, required nums=0 cout=0",
                             i, nums, cout);
                end
                rstn = 1'b1;
                k = 0;
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        k     = 0;
        rstn  = 1'b0;
        test_reset();
        test_full_sequence();
        test_wrap_second_lap();
        test_async_reset_mid();
        test_reset_at_terminal();
        test_long_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_counter_60
`default_nettype wire
